// File: rtl/mask_unit_pkg.sv
// Shared types and widths for the mask-unit read path (crossbar and per-lane trackers).
package mask_unit_pkg;

    localparam int unsigned VS_WIDTH   = 5;
    localparam int unsigned OFS_WIDTH  = 5;
    localparam int unsigned IDX_WIDTH  = 2;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BOFS_WIDTH = 2;

    // Tag kept for each read while it is in flight in the VRF
    typedef struct packed {
        logic [IDX_WIDTH-1:0]  writeIndex;
        logic [BOFS_WIDTH-1:0] dataOffset;
    } read_tag_t;

    // Aligned result waiting to be returned to the mask unit
    typedef struct packed {
        logic [IDX_WIDTH-1:0]  writeIndex;
        logic [DATA_WIDTH-1:0] data;
    } read_resp_t;

    // Shift the word right by whole bytes, zero-filling the top
    function automatic logic [DATA_WIDTH-1:0] align_word(
        input logic [DATA_WIDTH-1:0] word,
        input logic [BOFS_WIDTH-1:0] byte_ofs
    );
        return word >> {byte_ofs, 3'b000};
    endfunction

endpackage

// File: rtl/mask_unit_sync_fifo.sv
// Synchronous FIFO with registered storage; push and pop in one cycle are honoured even when full.
module mask_unit_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally; the count separates full from empty
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage write; no reset needed since empty slots are never presented
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mask_unit_read_tracker.sv
// Per-lane read tracker: issues crossbar reads to the VRF, tags them, aligns results and returns them in order.
module mask_unit_read_tracker
    import mask_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  req_ready,
    input  logic                  req_valid,
    input  logic [VS_WIDTH-1:0]   req_bits_vs,
    input  logic [OFS_WIDTH-1:0]  req_bits_offset,
    input  logic [IDX_WIDTH-1:0]  req_bits_writeIndex,
    input  logic [BOFS_WIDTH-1:0] req_bits_dataOffset,
    output logic                  vrfRead_valid,
    input  logic                  vrfRead_ready,
    output logic [VS_WIDTH-1:0]   vrfRead_bits_vs,
    output logic [OFS_WIDTH-1:0]  vrfRead_bits_offset,
    input  logic                  vrfResult_valid,
    input  logic [DATA_WIDTH-1:0] vrfResult_bits,
    input  logic                  resp_ready,
    output logic                  resp_valid,
    output logic [IDX_WIDTH-1:0]  resp_bits_writeIndex,
    output logic [DATA_WIDTH-1:0] resp_bits_data,
    output logic                  protocolError
);

    localparam int unsigned CREDIT_W = $clog2(DEPTH) + 1;

    logic [CREDIT_W-1:0] credit;
    logic                room;
    logic                issue;
    logic                resp_fire;
    logic                result_orphan;
    logic                result_push;
    logic                error_q;
    read_tag_t           tag_in;
    read_tag_t           tag_head;
    logic                tag_empty;
    read_resp_t          resp_in;
    read_resp_t          resp_head;
    logic                resp_empty;

    // Issue path: a credit slot must be free; nothing is issued while in reset
    assign room                = reset && (credit < CREDIT_W'(DEPTH));
    assign vrfRead_valid       = req_valid && room;
    assign req_ready           = vrfRead_ready && room;
    assign issue               = req_valid && req_ready;
    assign vrfRead_bits_vs     = req_bits_vs;
    assign vrfRead_bits_offset = req_bits_offset;

    // Result path: pair with the oldest tag, or flag an orphan result
    assign result_orphan = vrfResult_valid && tag_empty;
    assign result_push   = vrfResult_valid && !tag_empty;

    always_comb begin
        tag_in            = '0;
        tag_in.writeIndex = req_bits_writeIndex;
        tag_in.dataOffset = req_bits_dataOffset;
        resp_in            = '0;
        resp_in.writeIndex = tag_head.writeIndex;
        resp_in.data       = align_word(vrfResult_bits, tag_head.dataOffset);
    end

    // Response path straight from the data FIFO head
    assign resp_valid           = !resp_empty;
    assign resp_fire            = resp_valid && resp_ready;
    assign resp_bits_writeIndex = resp_head.writeIndex;
    assign resp_bits_data       = resp_head.data;
    assign protocolError        = error_q;

    mask_unit_sync_fifo #(
        .T     (read_tag_t),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (issue),
        .push_data (tag_in),
        .pop       (vrfResult_valid),
        .head      (tag_head),
        .empty     (tag_empty)
    );

    mask_unit_sync_fifo #(
        .T     (read_resp_t),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (result_push),
        .push_data (resp_in),
        .pop       (resp_fire),
        .head      (resp_head),
        .empty     (resp_empty)
    );

    // Credit counts reads issued but not yet retired on the response port
    always_ff @(posedge clock) begin
        if (!reset) begin
            credit <= '0;
        end else begin
            credit <= credit + CREDIT_W'(issue) - CREDIT_W'(resp_fire);
        end
    end

    // Sticky orphan-result flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else if (result_orphan) begin
            error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mask_unit_read_tracker.sv
// Self-checking bench for mask_unit_read_tracker: queue-based reference model plus directed and random stimulus.
module tb_mask_unit_read_tracker;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_ready;
    logic        req_valid = 1'b0;
    logic [4:0]  req_bits_vs = '0;
    logic [4:0]  req_bits_offset = '0;
    logic [1:0]  req_bits_writeIndex = '0;
    logic [1:0]  req_bits_dataOffset = '0;
    logic        vrfRead_valid;
    logic        vrfRead_ready = 1'b1;
    logic [4:0]  vrfRead_bits_vs;
    logic [4:0]  vrfRead_bits_offset;
    logic        vrfResult_valid = 1'b0;
    logic [31:0] vrfResult_bits = '0;
    logic        resp_ready = 1'b0;
    logic        resp_valid;
    logic [1:0]  resp_bits_writeIndex;
    logic [31:0] resp_bits_data;
    logic        protocolError;

    mask_unit_read_tracker #(.DEPTH(DEPTH)) dut (
        .clock                (clock),
        .reset                (reset),
        .req_ready            (req_ready),
        .req_valid            (req_valid),
        .req_bits_vs          (req_bits_vs),
        .req_bits_offset      (req_bits_offset),
        .req_bits_writeIndex  (req_bits_writeIndex),
        .req_bits_dataOffset  (req_bits_dataOffset),
        .vrfRead_valid        (vrfRead_valid),
        .vrfRead_ready        (vrfRead_ready),
        .vrfRead_bits_vs      (vrfRead_bits_vs),
        .vrfRead_bits_offset  (vrfRead_bits_offset),
        .vrfResult_valid      (vrfResult_valid),
        .vrfResult_bits       (vrfResult_bits),
        .resp_ready           (resp_ready),
        .resp_valid           (resp_valid),
        .resp_bits_writeIndex (resp_bits_writeIndex),
        .resp_bits_data       (resp_bits_data),
        .protocolError        (protocolError)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: tags in flight, aligned responses waiting, reads not yet retired
    logic [3:0]  tagq[$];
    logic [33:0] respq[$];
    int          outstanding = 0;
    bit          perr = 1'b0;
    bit          check_en = 1'b0;

    logic [1:0]  ord_wi   [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
    logic [1:0]  ord_doff [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
    logic [31:0] ord_word [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    logic [31:0] ord_exp  [4] = '{32'h11223344, 32'h00000055, 32'h000099AA, 32'h00DDEEFF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every active edge, from the sampled inputs and the model's own view of credit
    always @(posedge clock) begin
        bit         room_m;
        bit         issue_m;
        bit         fire_m;
        logic [3:0] t;
        if (!reset) begin
            tagq.delete();
            respq.delete();
            outstanding = 0;
            perr = 1'b0;
        end else begin
            room_m  = outstanding < DEPTH;
            issue_m = req_valid && vrfRead_ready && room_m;
            fire_m  = (respq.size() != 0) && resp_ready;
            if (fire_m) begin
                void'(respq.pop_front());
                outstanding--;
            end
            if (vrfResult_valid) begin
                if (tagq.size() == 0) begin
                    perr = 1'b1;
                end else begin
                    t = tagq.pop_front();
                    respq.push_back({t[3:2], 32'(vrfResult_bits >> (8 * int'(t[1:0])))});
                end
            end
            if (issue_m) begin
                tagq.push_back({req_bits_writeIndex, req_bits_dataOffset});
                outstanding++;
            end
            checks++;
            if (outstanding < 0 || outstanding > DEPTH) begin
                errors++;
                $display("FAIL credit_range actual=%0d required=0..%0d at %0t", outstanding, DEPTH, $time);
            end
        end
    end

    // Compare DUT outputs with the model each cycle, away from the active edge
    always @(negedge clock) begin
        bit room_e;
        if (check_en) begin
            room_e = reset && (outstanding < DEPTH);
            chk("req_ready", 64'(req_ready), 64'(vrfRead_ready && room_e));
            chk("vrfRead_valid", 64'(vrfRead_valid), 64'(req_valid && room_e));
            chk("vrfRead_bits", 64'({vrfRead_bits_vs, vrfRead_bits_offset}),
                64'({req_bits_vs, req_bits_offset}));
            chk("resp_valid", 64'(resp_valid), 64'(respq.size() != 0));
            if (respq.size() != 0)
                chk("resp_bits", 64'({resp_bits_writeIndex, resp_bits_data}), 64'(respq[0]));
            chk("protocolError", 64'(protocolError), 64'(perr));
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid           = 1'b0;
        req_bits_vs         = '0;
        req_bits_offset     = '0;
        req_bits_writeIndex = '0;
        req_bits_dataOffset = '0;
        vrfRead_ready       = 1'b1;
        vrfResult_valid     = 1'b0;
        vrfResult_bits      = '0;
        resp_ready          = 1'b0;
    endtask

    task automatic rand_req();
        req_bits_vs         = 5'($urandom);
        req_bits_offset     = 5'($urandom);
        req_bits_writeIndex = 2'($urandom);
        req_bits_dataOffset = 2'($urandom);
    endtask

    // Return every pending result and retire every response, within a cycle budget
    task automatic drain();
        int n = 0;
        while ((tagq.size() != 0 || respq.size() != 0) && n < 200) begin
            req_valid       = 1'b0;
            resp_ready      = 1'b1;
            vrfResult_valid = (tagq.size() != 0);
            vrfResult_bits  = $urandom;
            next();
            n++;
        end
        chk("drain_timeout", 64'(n >= 200), 64'(0));
        idle();
    endtask

    initial begin
        idle();
        reset     = 1'b0;
        req_valid = 1'b1;
        next();
        check_en = 1'b1;

        // Reset held with a request pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("rst_protocolError", 64'(protocolError), 64'(0));
            chk("rst_vrfRead_valid", 64'(vrfRead_valid), 64'(0));
            next();
        end
        reset = 1'b1;
        idle();
        next();

        // Single read, result one cycle later, response the cycle after
        req_valid = 1'b1; req_bits_vs = 5'd3; req_bits_offset = 5'd7;
        req_bits_writeIndex = 2'd2; req_bits_dataOffset = 2'd1;
        @(negedge clock);
        chk("single_vs", 64'(vrfRead_bits_vs), 64'(3));
        chk("single_offset", 64'(vrfRead_bits_offset), 64'(7));
        chk("single_req_ready", 64'(req_ready), 64'(1));
        next();
        idle();
        vrfResult_valid = 1'b1; vrfResult_bits = 32'hAABBCCDD;
        @(negedge clock);
        chk("single_resp_early", 64'(resp_valid), 64'(0));
        next();
        idle();
        resp_ready = 1'b1;
        @(negedge clock);
        chk("single_resp_valid", 64'(resp_valid), 64'(1));
        chk("single_resp_wi", 64'(resp_bits_writeIndex), 64'(2));
        chk("single_resp_data", 64'(resp_bits_data), 64'h00AABBCC);
        next();
        idle();
        @(negedge clock);
        chk("single_resp_gone", 64'(resp_valid), 64'(0));
        next();

        // Credit full: four issues with no response retired
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; rand_req();
            vrfResult_valid = (tagq.size() != 0); vrfResult_bits = $urandom;
            @(negedge clock);
            chk("credit_fill_ready", 64'(req_ready), 64'(1));
            next();
        end
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; rand_req();
            vrfResult_valid = (tagq.size() != 0); vrfResult_bits = $urandom;
            @(negedge clock);
            chk("credit_full_ready", 64'(req_ready), 64'(0));
            chk("credit_full_vrf_valid", 64'(vrfRead_valid), 64'(0));
            next();
        end
        req_valid = 1'b1; vrfResult_valid = (tagq.size() != 0); resp_ready = 1'b1;
        @(negedge clock);
        chk("credit_fire_resp_valid", 64'(resp_valid), 64'(1));
        chk("credit_fire_ready", 64'(req_ready), 64'(0));
        next();
        resp_ready = 1'b0; vrfResult_valid = (tagq.size() != 0);
        @(negedge clock);
        chk("credit_reopen_ready", 64'(req_ready), 64'(1));
        chk("credit_reopen_issue", 64'(vrfRead_valid), 64'(1));
        next();
        vrfResult_valid = (tagq.size() != 0);
        @(negedge clock);
        chk("credit_refull_ready", 64'(req_ready), 64'(0));
        next();
        drain();

        // Ordering and alignment across writeIndex values
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; rand_req();
            req_bits_writeIndex = ord_wi[i]; req_bits_dataOffset = ord_doff[i];
            next();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            vrfResult_valid = 1'b1; vrfResult_bits = ord_word[i];
            next();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            resp_ready = 1'b1;
            @(negedge clock);
            chk("order_valid", 64'(resp_valid), 64'(1));
            chk("order_wi", 64'(resp_bits_writeIndex), 64'(ord_wi[i]));
            chk("order_data", 64'(resp_bits_data), 64'(ord_exp[i]));
            next();
        end
        idle();
        drain();

        // Issue, result and response fire in one cycle at credit 2
        req_valid = 1'b1; rand_req(); next();
        req_valid = 1'b1; rand_req(); next();
        idle(); vrfResult_valid = 1'b1; vrfResult_bits = $urandom; next();
        req_valid = 1'b1; rand_req();
        vrfResult_valid = 1'b1; vrfResult_bits = $urandom; resp_ready = 1'b1;
        @(negedge clock);
        chk("simul_pre_credit", 64'(dut.credit), 64'(2));
        chk("simul_pre_data_cnt", 64'(dut.u_data_fifo.count), 64'(1));
        chk("simul_pre_tag_cnt", 64'(dut.u_tag_fifo.count), 64'(1));
        chk("simul_req_ready", 64'(req_ready), 64'(1));
        chk("simul_resp_valid", 64'(resp_valid), 64'(1));
        next();
        idle();
        @(negedge clock);
        chk("simul_post_credit", 64'(dut.credit), 64'(2));
        chk("simul_post_data_cnt", 64'(dut.u_data_fifo.count), 64'(1));
        chk("simul_post_tag_cnt", 64'(dut.u_tag_fifo.count), 64'(1));
        next();
        drain();

        // Orphan result with nothing issued
        vrfResult_valid = 1'b1; vrfResult_bits = 32'hDEADBEEF;
        next();
        idle();
        for (int i = 0; i < 4; i++) begin
            req_valid = (i == 1); rand_req();
            vrfResult_valid = (tagq.size() != 0);
            resp_ready = (i == 3);
            @(negedge clock);
            chk("orphan_error", 64'(protocolError), 64'(1));
            if (i == 0) chk("orphan_no_resp", 64'(resp_valid), 64'(0));
            next();
        end
        drain();
        reset = 1'b0; next();
        reset = 1'b1;
        @(negedge clock);
        chk("orphan_cleared", 64'(protocolError), 64'(0));
        next();

        // Read in flight across reset: its late result is an orphan
        req_valid = 1'b1; rand_req(); next();
        idle(); reset = 1'b0; next();
        reset = 1'b1; vrfResult_valid = 1'b1; vrfResult_bits = $urandom; next();
        idle();
        @(negedge clock);
        chk("abandoned_error", 64'(protocolError), 64'(1));
        chk("abandoned_no_resp", 64'(resp_valid), 64'(0));
        reset = 1'b0; next();
        reset = 1'b1; next();

        // Randomised traffic with bursts of response backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid       = ($urandom % 4) != 0;
            rand_req();
            vrfRead_ready   = ($urandom % 4) != 0;
            vrfResult_valid = (tagq.size() != 0) && (($urandom % 2) == 0);
            vrfResult_bits  = $urandom;
            resp_ready      = (((cyc / 40) % 3) == 2) ? 1'b0 : (($urandom % 3) != 0);
            next();
        end
        idle();
        drain();
        @(negedge clock);
        chk("final_idle_resp", 64'(resp_valid), 64'(0));
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
